// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Purpose  : Bit-serial subtractor with borrow. Computes
//            {bo, d} = a - b - bi one bit per clock, LSB first. Uses the
//            full-adder cell structure with a borrow chain instead of a
//            carry chain. Start/done handshake towards a controlling block.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            start - request pulse, sampled only when not busy
//            a, b  - minuend / subtrahend (WIDTH bits), sampled on accept
//            bi    - borrow in, sampled on accept
//            busy  - high while the serial step is running
//            done  - one-cycle completion pulse
//            d     - registered difference, holds until next completion
//            bo    - registered borrow out, holds with d
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sd;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_bo;

    logic               w_x;
    logic               w_y;
    logic               w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_sd_next;

    // One full-subtractor bit cell.
    assign w_x      = r_sa[0];
    assign w_y      = r_sb[0];
    assign w_diff   = w_x ^ w_y ^ r_br;
    assign w_borrow = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);

    // The new difference bit enters at the MSB, so after WIDTH steps the
    // first (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_sd_single
            assign w_sd_next = w_diff;
        end else begin : g_sd_multi
            assign w_sd_next = {w_diff, r_sd[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new request too, giving back-to-back ops.
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bi;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sd  <= w_sd_next;
                    r_br  <= w_borrow;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) begin
                        r_d     <= w_sd_next;
                        r_bo    <= w_borrow;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bo   = r_bo;

endmodule
`default_nettype wire

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor with borrow: computes {bo, d} = a - b - bi, one bit per clock, LSB first.
- Inverse-direction companion to the team's ripple-carry adders. It shares the full-adder bit cell's structure, but its chain is a borrow chain, not a carry chain.
- Sits beside the adders as the area-cheap subtract path. Driven by a start/done handshake from a controlling block.

Parameters:
- WIDTH, 4, operand and result width in bits (WIDTH >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bi  input  1  borrow in; sampled on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; d and bo are valid from this cycle onward.
- d  output  WIDTH  difference, registered; holds until the next completion.
- bo  output  1  borrow out, registered; holds with d.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-operation):
  - state goes to IDLE; busy=0, done=0, d=0, bo=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: latch a into sa and b into sb, br<=bi, cnt<=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT: each edge performs one bit step.
  - x=sa[0], y=sb[0].
  - diff bit = x ^ y ^ br.
  - br <= (~x & y) | (~x & br) | (y & br).
  - sa and sb shift right by 1.
  - The diff bit shifts into the MSB of the accumulator sd, which also shifts right.
  - cnt <= cnt+1.
  - On the step where cnt == WIDTH-1: d <= final sd (including this bit) and bo <= final br; go to DONE.
  - Exactly WIDTH edges are spent in SHIFT.
- DONE:
  - done=1 for this cycle only.
  - start=1 at the edge: accepted exactly as in IDLE, go to SHIFT. This permits back-to-back operation.
  - start=0: go to IDLE.
- Latency:
  - start sampled at edge E.
  - busy=1 from edge E through edge E+WIDTH.
  - done=1 in the cycle following edge E+WIDTH.
  - d and bo update at edge E+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy (SHIFT): ignored; no effect on the operation in flight.
- Inputs a, b and bi may change freely after the accepting edge.
- busy and done are registered, state-decoded outputs (no combinational path from start).
- Arithmetic:
  - {bo, d} equals (a - b - bi) modulo 2^(WIDTH+1), with operands zero-extended.
  - bo=1 exactly when a < b + bi (unsigned).
  - d is the two's-complement low WIDTH bits.
- Boundary cases:
  - a=b, bi=0: d=0, bo=0.
  - a=0, b=0, bi=1: d=all ones, bo=1.
  - WIDTH=1: SHIFT lasts one cycle.
- cnt width: clog2(WIDTH)+1 bits; no wrap within an operation.

Test Plan:
- Basic difference: rst then a=5, b=3, bi=0, start=1 for one cycle -> busy high 4 cycles; done pulse on the 5th cycle; d=4'd2, bo=0.
- Negative result: a=3, b=5, bi=0 -> d=4'b1110, bo=1.
- Borrow-in edge cases:
  - a=0, b=0, bi=1 -> d=4'b1111, bo=1.
  - a=15, b=15, bi=1 -> d=4'b1111, bo=1.
  - a=15, b=0, bi=0 -> d=15, bo=0.
- Ignored start and back-to-back:
  - Start a=9, b=4; pulse start again with a=1, b=7 two cycles later -> result d=5, bo=0, and only one done pulse.
  - start asserted in the DONE cycle with a=1, b=2 -> next done after 5 more cycles, with d=15, bo=1.
- Reset mid-operation: assert rst in the 2nd SHIFT cycle -> next cycle busy=0, done=0, d=0, bo=0. A fresh start then completes correctly.
- Exhaustive check: all 512 (a, b, bi) combinations at WIDTH=4, each result compared against a - b - bi in 5 bits. Repeat a subset at WIDTH=1 and WIDTH=8.
